// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the MEM-stage load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    return f[1] ? |a : f[0] ? a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: req/ready data-bus between the LSU master and the data memory slave
interface lsu_dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  modport master (output req, we, addr, be, wdata, input ready, rdata);
  modport slave (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-enable generation, store lane replication and load extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic byte_sz, half_sz, uns;
  logic [7:0] b;
  logic [15:0] h;
  assign byte_sz = funct3[1:0] == FUNCT3_B[1:0];
  assign half_sz = funct3[1:0] == FUNCT3_H[1:0];
  assign uns = funct3 == FUNCT3_BU || funct3 == FUNCT3_HU;
  assign b = rdata[{a, 3'b000} +: 8];
  assign h = a[1] ? rdata[31:16] : rdata[15:0];
  always_comb begin
    be = byte_sz ? 4'b0001 << a : half_sz ? 4'b0011 << {a[1], 1'b0} : 4'hF;
    wdata = byte_sz ? {4{wd[7:0]}} : half_sz ? {2{wd[15:0]}} : wd;
    ldata = byte_sz ? {{24{b[7] & ~uns}}, b} : half_sz ? {{16{h[15] & ~uns}}, h} : rdata;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage req/ready load/store bus master with stall and timeout; MEM_MISALIGN_TRAP_EN adds misalign trap
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [2:0]  Funct3_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemWriteData_mem,
  output logic        MemStall,
  output logic [31:0] MemDout_mem,
  output logic        BusErr,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        MisalignErr,
`endif
  lsu_dmem_if.master  dmem
);
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d, ldata;
  logic buserr_q, buserr_d;
  logic access, mis, trap, timeout;
  assign access = MemRead_mem | MemWrite_mem;
`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis = misaligned(Funct3_mem, ALUResult_mem[1:0]);
  always_ff @(posedge clk or negedge reset)
    if (!reset) mis_q <= 1'b0;
    else mis_q <= trap;
  assign MisalignErr = mis_q;
`else
  assign mis = 1'b0;
`endif
  lsu_align u_align (
    .funct3(Funct3_mem),
    .a     (ALUResult_mem[1:0]),
    .wd    (MemWriteData_mem),
    .rdata (dmem.rdata),
    .be    (dmem.be),
    .wdata (dmem.wdata),
    .ldata (ldata)
  );
  assign trap = state_q == IDLE && access && mis;
  assign timeout = state_q == BUSY && !dmem.ready && cnt_q == TMO;
  assign dmem.req = reset && (state_q == BUSY || (state_q == IDLE && access && !mis));
  assign MemStall = reset && (state_q == BUSY || (state_q == IDLE && access));
  assign dmem.we = MemWrite_mem;
  assign dmem.addr = {ALUResult_mem[31:2], 2'b00};
  assign MemDout_mem = dout_q;
  assign BusErr = buserr_q;
  always_comb begin
    state_d = state_q == DONE ? IDLE
            : state_q == BUSY ? ((dmem.ready || timeout) ? DONE : BUSY)
            : access ? ((mis || dmem.ready) ? DONE : BUSY) : IDLE;
    cnt_d = state_q == BUSY ? cnt_q + 8'd1 : 8'd1;
    buserr_d = timeout;
    dout_d = (dmem.req && dmem.ready && !MemWrite_mem) ? ldata : (timeout || trap) ? '0 : dout_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dout_q <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      buserr_q <= buserr_d;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed table-driven checks of mem_stage_lsu with a 4-cycle timeout
module tb_mem_stage_lsu;
  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdata;
    int delay, stall;
    logic we;
    logic [31:0] baddr;
    logic [3:0] be;
    logic [31:0] bwd, dout;
    logic berr;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic rd = 1'b0, wr = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0, wd = '0;
  logic stall, berr;
  logic [31:0] dout;
  int tests = 0, fails = 0;
  vec_t v[$];
  lsu_dmem_if bus();
`ifdef MEM_MISALIGN_TRAP_EN
  logic merr;
`endif
  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .MemRead_mem     (rd),
    .MemWrite_mem    (wr),
    .Funct3_mem      (f3),
    .ALUResult_mem   (addr),
    .MemWriteData_mem(wd),
    .MemStall        (stall),
    .MemDout_mem     (dout),
    .BusErr          (berr),
`ifdef MEM_MISALIGN_TRAP_EN
    .MisalignErr     (merr),
`endif
    .dmem            (bus.master)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t t, input string nm);
    int k;
    logic ok;
    @(negedge clk);
    rd = t.rd; wr = t.wr; f3 = t.f3; addr = t.addr; wd = t.wd;
    bus.rdata = t.rdata; bus.ready = t.delay == 0;
    k = 0; ok = 1'b1;
    #1;
    while (stall && k < 20) begin
      if (!(bus.req === 1'b1 && bus.we === t.we && bus.addr === t.baddr &&
            bus.be === t.be && bus.wdata === t.bwd)) ok = 1'b0;
      k++;
      @(negedge clk);
      bus.ready = k == t.delay;
      #1;
    end
    chk({nm, " stall_cycles"}, k, t.stall);
    chk({nm, " bus_fields"}, {31'd0, ok}, 32'd1);
    chk({nm, " dout"}, dout, t.dout);
    chk({nm, " buserr"}, {31'd0, berr}, {31'd0, t.berr});
    chk({nm, " req_in_done"}, {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    rd = 0; wr = 0; bus.ready = 0;
    #1;
    chk({nm, " idle_after"}, {30'd0, berr, stall}, 32'd0);
  endtask
  initial begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    //          rd wr f3   addr       wd           rdata        dly stl we baddr      be       bwd          dout         berr
    v.push_back('{1, 0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h104, 4'hF,    32'h0,        32'hDEADBEEF, 0});
    v.push_back('{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 1, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 0});
    v.push_back('{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 1, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 0});
    v.push_back('{0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        3, 4, 1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080, 0});
    v.push_back('{1, 0, 3'b001, 32'h106, 32'h0,        32'h80017FFF, 1, 2, 0, 32'h104, 4'b1100, 32'h0,        32'hFFFF8001, 0});
    v.push_back('{1, 0, 3'b101, 32'h104, 32'h0,        32'h8001F00D, 2, 3, 0, 32'h104, 4'b0011, 32'h0,        32'h0000F00D, 0});
    v.push_back('{0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        0, 1, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0000F00D, 0});
    v.push_back('{0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        1, 2, 1, 32'h300, 4'hF,    32'hCAFEF00D, 32'h0000F00D, 0});
    v.push_back('{1, 0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0, 1, 0, 32'h000, 4'b0010, 32'h0,        32'h0000007F, 0});
    v.push_back('{1, 0, 3'b010, 32'h400, 32'h0,        32'h55555555, 99, 5, 0, 32'h400, 4'hF,   32'h0,        32'h00000000, 1});
    v.push_back('{1, 0, 3'b011, 32'h010, 32'h0,        32'h12345678, 0, 1, 0, 32'h010, 4'hF,    32'h0,        32'h12345678, 0});
    v.push_back('{1, 1, 3'b010, 32'h020, 32'h11223344, 32'h99999999, 0, 1, 1, 32'h020, 4'hF,    32'h11223344, 32'h12345678, 0});
`ifndef MEM_MISALIGN_TRAP_EN
    v.push_back('{1, 0, 3'b010, 32'h101, 32'h0,        32'hA5A55A5A, 0, 1, 0, 32'h100, 4'hF,    32'h0,        32'hA5A55A5A, 0});
`endif
    v.push_back('{0, 1, 3'b000, 32'h003, 32'h00000077, 32'h0,        99, 5, 1, 32'h000, 4'b1000, 32'h77777777, 32'h00000000, 1});
    v.push_back('{1, 0, 3'b010, 32'h008, 32'h0,        32'h0BADF00D, 4, 5, 0, 32'h008, 4'hF,    32'h0,        32'h0BADF00D, 0});
    repeat (2) @(negedge clk);
    #1;
    chk("reset dout", dout, 32'd0);
    chk("reset flags", {29'd0, berr, stall, bus.req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < v.size(); i++) run(v[i], $sformatf("vec%0d", i));
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    rd = 1; f3 = 3'b010; addr = 32'h101; bus.ready = 0;
    #1;
    chk("mis stall", {30'd0, stall, bus.req}, 32'd2);
    @(negedge clk);
    #1;
    chk("mis done", {29'd0, merr, stall, bus.req}, 32'd4);
    chk("mis dout", dout, 32'd0);
    @(negedge clk);
    rd = 0;
    #1;
    chk("mis pulse", {31'd0, merr}, 32'd0);
`endif
    @(negedge clk);
    rd = 1; f3 = 3'b010; addr = 32'h500; bus.ready = 0; bus.rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("pre-reset busy", {30'd0, stall, bus.req}, 32'd3);
    reset = 1'b0;
    #1;
    chk("async reset flags", {29'd0, berr, stall, bus.req}, 32'd0);
    chk("async reset dout", dout, 32'd0);
    @(negedge clk);
    rd = 0; bus.ready = 1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.ready = 0;
    #1;
    chk("post-reset ignore", {stall, dout[30:0]}, 32'd0);
    run('{1, 0, 3'b010, 32'h104, 32'h0, 32'h13572468, 0, 1, 0, 32'h104, 4'hF, 32'h0, 32'h13572468, 0}, "recover");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
